// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 8-bit accumulator CPU.
// Owns pc, ir, data_reg and acc, drives the ALU and a byte-wide memory with
// combinational read. Each instruction is two bytes, high byte first.
// Optional macro SEQ_STEP_EN adds a 'step' input that gates every S0 fetch.
//
// Memory/ALU handshake: strobes are asserted only in ena-high cycles outside
// reset; mem_rdata is consumed on the same clock edge that ends the mem_rd
// cycle, and mem_wr lasts exactly the one S5 cycle of a STO.
module cpu_sequencer #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
`ifdef SEQ_STEP_EN
    input  logic          step,
`endif
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    alu_opcode,
    output logic [DW-1:0] alu_accum,
    output logic [DW-1:0] alu_data,
    input  logic [DW-1:0] alu_out,
    output logic          zero,
    output logic          halted
);

    localparam int IW = 2 * DW;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [2:0] ALU_ACC = 3'b110;

    typedef enum logic [2:0] {
        S0     = 3'd0,
        S1     = 3'd1,
        S2     = 3'd2,
        S3     = 3'd3,
        S4     = 3'd4,
        S5     = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [IW-1:0] ir;
    logic [DW-1:0] data_reg;
    logic [DW-1:0] acc;

    logic [2:0]    op_f;
    logic [AW-1:0] addr_f;
    logic          rd_op;
    logic          run;
    logic          fetch_go;

    assign op_f   = ir[IW-1 -: 3];
    assign addr_f = ir[AW-1:0];
    assign rd_op  = (op_f == OP_ADD) || (op_f == OP_AND) ||
                    (op_f == OP_XOR) || (op_f == OP_LDA);
    // Strobes need both a live enable and a released reset.
    assign run    = ena & rst_n;

`ifdef SEQ_STEP_EN
    logic step_wait;
    assign fetch_go = !step_wait || step;
`else
    assign fetch_go = 1'b1;
`endif

    // ALU operation for the decoded instruction.
    function automatic logic [2:0] alu_sel(input logic [2:0] op);
        case (op)
            OP_ADD:  alu_sel = 3'b100;
            OP_AND:  alu_sel = 3'b000;
            OP_XOR:  alu_sel = 3'b011;
            OP_LDA:  alu_sel = 3'b111;
            default: alu_sel = ALU_ACC;
        endcase
    endfunction

    // Sequencer FSM: one state per ena-high cycle; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S0;
            pc         <= '0;
            ir         <= '0;
            data_reg   <= '0;
            acc        <= '0;
            alu_opcode <= ALU_ACC;
`ifdef SEQ_STEP_EN
            step_wait  <= 1'b1;
`endif
        end else if (ena) begin
            case (state)
                S0: begin
                    if (fetch_go) begin
                        ir[IW-1:DW] <= mem_rdata;
                        pc          <= pc + AW'(1);
                        state       <= S1;
`ifdef SEQ_STEP_EN
                        step_wait   <= 1'b0;
`endif
                    end
                end
                S1: begin
                    ir[DW-1:0] <= mem_rdata;
                    pc         <= pc + AW'(1);
                    alu_opcode <= alu_sel(op_f);
                    state      <= S2;
                end
                S2: state <= (op_f == OP_HLT) ? S_HALT : S3;
                S3: begin
                    if (rd_op) data_reg <= mem_rdata;
                    state <= S4;
                end
                S4: begin
                    if (rd_op) acc <= alu_out;
                    state <= S5;
                end
                S5: begin
                    if (op_f == OP_SKZ && zero) pc <= pc + AW'(2);
                    else if (op_f == OP_JMP)    pc <= addr_f;
                    alu_opcode <= ALU_ACC;
                    state      <= S0;
`ifdef SEQ_STEP_EN
                    step_wait  <= 1'b1;
`endif
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Memory address and strobes decoded from the current state.
    always_comb begin
        mem_addr = addr_f;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        case (state)
            S0: begin
                mem_addr = pc;
                mem_rd   = run & fetch_go;
            end
            S1: begin
                mem_addr = pc;
                mem_rd   = run;
            end
            S3:      mem_rd = run & rd_op;
            S5:      mem_wr = run & (op_f == OP_STO);
            S_HALT:  mem_addr = pc;
            default: mem_addr = addr_f;
        endcase
    end

    assign mem_wdata = acc;
    assign alu_accum = acc;
    assign alu_data  = data_reg;
    assign zero      = (acc == '0);
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: an instruction-level model of the CPU predicts the
// ordered list of bus events (reads and writes) plus final accumulator; a
// monitor pops and compares each strobed bus cycle as the DUT presents it.
module tb_cpu_sequencer;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int EW = 1 + AW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    alu_opcode;
    logic [DW-1:0] alu_accum;
    logic [DW-1:0] alu_data;
    logic [DW-1:0] alu_out;
    logic          zero;
    logic          halted;
`ifdef SEQ_STEP_EN
    logic          step = 1'b1;
`endif

    cpu_sequencer #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef SEQ_STEP_EN
        .step(step),
`endif
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .alu_opcode(alu_opcode), .alu_accum(alu_accum), .alu_data(alu_data),
        .alu_out(alu_out), .zero(zero), .halted(halted)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- environment: memory and ALU ----------------
    logic [7:0] mem [0:8191];
    logic [7:0] model_mem [0:8191];

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    always_comb begin
        case (alu_opcode)
            3'b100:  alu_out = alu_accum + alu_data;
            3'b000:  alu_out = alu_accum & alu_data;
            3'b011:  alu_out = alu_accum ^ alu_data;
            3'b111:  alu_out = alu_data;
            default: alu_out = alu_accum;
        endcase
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];
    bit         sb_en = 1'b0;
    int         m_exec;
    bit         m_halt;
    logic [7:0] m_acc;
    int         last_cnt;
    int         wr_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // ---------------- reference model (instruction level) ----------------
    task automatic model_run(input int max_instr);
        int pc;
        logic [7:0]  acc;
        logic [15:0] ins;
        logic [2:0]  op;
        logic [12:0] a;
        logic [7:0]  d;
        pc = 0; acc = 8'h00; m_exec = 0; m_halt = 1'b0;
        while (m_exec < max_instr) begin
            exp_q.push_back({1'b0, 13'(pc), 8'h00});
            ins[15:8] = model_mem[pc];
            pc = (pc + 1) % 8192;
            exp_q.push_back({1'b0, 13'(pc), 8'h00});
            ins[7:0] = model_mem[pc];
            pc = (pc + 1) % 8192;
            op = ins[15:13];
            a  = ins[12:0];
            if (op == 3'b000) begin
                m_halt = 1'b1;
                break;
            end
            m_exec++;
            case (op)
                3'b010, 3'b011, 3'b100, 3'b101: begin
                    exp_q.push_back({1'b0, a, 8'h00});
                    d = model_mem[a];
                    if (op == 3'b010)      acc = acc + d;
                    else if (op == 3'b011) acc = acc & d;
                    else if (op == 3'b100) acc = acc ^ d;
                    else                   acc = d;
                end
                3'b110: begin
                    exp_q.push_back({1'b1, a, acc});
                    model_mem[a] = acc;
                end
                3'b001: if (acc == 8'h00) pc = (pc + 2) % 8192;
                default: pc = int'(a);
            endcase
        end
        m_acc = acc;
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit            edge_held = 1'b0;
    bit            prev_ok = 1'b0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_acc, last_dat;

    always @(posedge clk) edge_held = rst_n && !ena;

    always @(negedge clk) begin
        logic [EW-1:0] got, e;
        if (rst_n) begin
            check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'(0));
            check("wdata_is_acc", 32'(mem_wdata), 32'(alu_accum));
            if (!ena) check("strobes_when_held", 32'({mem_rd, mem_wr}), 32'(0));
            if (prev_ok && edge_held) begin
                check("held_addr", 32'(mem_addr), 32'(last_addr));
                check("held_acc", 32'(alu_accum), 32'(last_acc));
                check("held_data", 32'(alu_data), 32'(last_dat));
            end
            if (sb_en && (mem_rd || mem_wr)) begin
                got = {mem_wr, mem_addr, (mem_wr ? mem_wdata : 8'h00)};
                if (mem_wr) wr_count++;
                if (exp_q.size() == 0) fail_now("unexpected_bus_event", 32'(got));
                else begin
                    e = exp_q.pop_front();
                    check("bus_event", 32'(got), 32'(e));
                end
            end
        end
        prev_ok   = rst_n;
        last_addr = mem_addr;
        last_acc  = alu_accum;
        last_dat  = alu_data;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    endtask

    task automatic put_ins(input int a, input logic [2:0] op, input logic [12:0] f);
        mem[a % 8192]       = {op, f[12:8]};
        mem[(a + 1) % 8192] = f[7:0];
    endtask

    // Reset with ena high, check reset values, release just after a rising edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_mem_rd", 32'(mem_rd), 32'(0));
        check("rst_mem_wr", 32'(mem_wr), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        check("rst_acc", 32'(alu_accum), 32'(0));
        check("rst_data", 32'(alu_data), 32'(0));
        check("rst_opcode", 32'(alu_opcode), 32'(3'b110));
        check("rst_zero", 32'(zero), 32'(1));
        check("rst_pc_addr", 32'(mem_addr), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("first_fetch_rd", 32'(mem_rd), 32'(1));
        check("first_fetch_addr", 32'(mem_addr), 32'(0));
    endtask

    // Run the program in mem; hold_at < 0 gives random ena, otherwise ena is
    // held low for 4 cycles once hold_at ena-cycles have elapsed.
    task automatic run_prog(input int max_instr, input int hold_at);
        int cnt, cyc, hold_left;
        bit done, hold_done;
        for (int i = 0; i < 8192; i++) model_mem[i] = mem[i];
        exp_q.delete();
        model_run(max_instr);
        wr_count = 0;
        sb_en = 1'b1;
        apply_reset();
        cnt = 0; cyc = 0; hold_left = 0; done = 1'b0; hold_done = 1'b0;
        while (!done && cyc < 4000) begin
            @(posedge clk);
            cyc++;
            if (ena) cnt++;
            #1;
            if (m_halt ? (halted === 1'b1) : (cnt == 6 * m_exec)) done = 1'b1;
            else if (hold_at < 0) ena = ($urandom_range(0, 3) != 0);
            else begin
                if (cnt == hold_at && !hold_done) begin
                    hold_left = 4;
                    hold_done = 1'b1;
                end
                if (hold_left > 0) begin
                    ena = 1'b0;
                    hold_left--;
                    #1 check("hold_mem_rd", 32'(mem_rd), 32'(0));
                end else ena = 1'b1;
            end
        end
        if (!done) fail_now("run_timeout", 32'(cyc));
        ena = 1'b0;
        @(negedge clk);
        #1;
        last_cnt = cnt;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        if (m_halt) check("halt_latency", 32'(cnt), 32'(6 * m_exec + 3));
        check("final_acc", 32'(alu_accum), 32'(m_acc));
        check("final_zero", 32'(zero), 32'(m_acc == 8'h00));
        sb_en = 1'b0;
    endtask

    task automatic gen_random();
        int n;
        logic [2:0] op;
        logic [12:0] f;
        clear_mem();
        n = $urandom_range(4, 10);
        for (int i = 0; i < n; i++) begin
            op = 3'($urandom_range(1, 7));
            if (op == 3'b111) f = 13'(2 * $urandom_range(i + 1, n));
            else if (op == 3'b001) f = 13'($urandom_range(0, 8191));
            else f = 13'h1000 + 13'($urandom_range(0, 15));
            put_ins(2 * i, op, f);
        end
        for (int j = 0; j < 16; j++)
            mem[13'h1000 + j] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset mid-S3 of the second instruction.
        clear_mem();
        put_ins(0, 3'b101, 13'h0100);
        put_ins(2, 3'b010, 13'h0101);
        mem[13'h0100] = 8'h05;
        mem[13'h0101] = 8'h03;
        sb_en = 1'b0;
        apply_reset();
        repeat (9) @(posedge clk);
        #3;
        check("s3_pre_addr", 32'(mem_addr), 32'(13'h0101));
        check("s3_pre_rd", 32'(mem_rd), 32'(1));
        check("s3_pre_acc", 32'(alu_accum), 32'(8'h05));
        rst_n = 1'b0;
        #1;
        check("s3_rst_rd", 32'(mem_rd), 32'(0));
        check("s3_rst_acc", 32'(alu_accum), 32'(0));
        check("s3_rst_pc", 32'(mem_addr), 32'(0));
        check("s3_rst_halted", 32'(halted), 32'(0));

        // Reset during the S5 write of a STO.
        clear_mem();
        put_ins(0, 3'b101, 13'h0100);
        put_ins(2, 3'b110, 13'h0102);
        mem[13'h0100] = 8'h05;
        mem[13'h0102] = 8'hAA;
        apply_reset();
        repeat (11) @(posedge clk);
        #3;
        check("sto_pre_wr", 32'(mem_wr), 32'(1));
        check("sto_pre_addr", 32'(mem_addr), 32'(13'h0102));
        check("sto_pre_wdata", 32'(mem_wdata), 32'(8'h05));
        rst_n = 1'b0;
        #1;
        check("sto_rst_wr", 32'(mem_wr), 32'(0));
        @(posedge clk);
        #1;
        check("sto_no_write", 32'(mem[13'h0102]), 32'(8'hAA));
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("sto_restart_rd", 32'(mem_rd), 32'(1));
        check("sto_restart_addr", 32'(mem_addr), 32'(0));

        // LDA 0100; ADD 0101; STO 0102; HLT
        clear_mem();
        put_ins(0, 3'b101, 13'h0100);
        put_ins(2, 3'b010, 13'h0101);
        put_ins(4, 3'b110, 13'h0102);
        mem[13'h0100] = 8'h05;
        mem[13'h0101] = 8'h03;
        run_prog(100, 1000);
        check("prog_store", 32'(mem[13'h0102]), 32'(8'h08));
        check("prog_acc", 32'(alu_accum), 32'(8'h08));
        check("prog_cycles", 32'(last_cnt), 32'(21));
        check("prog_one_write", 32'(wr_count), 32'(1));
        check("prog_halted", 32'(halted), 32'(1));

        // SKZ with acc = 0: JMP skipped, LDA loads 05.
        clear_mem();
        put_ins(0, 3'b001, 13'h0000);
        put_ins(2, 3'b111, 13'h0000);
        put_ins(4, 3'b101, 13'h0100);
        mem[13'h0100] = 8'h05;
        run_prog(100, -1);
        check("skz_taken_acc", 32'(alu_accum), 32'(8'h05));

        // SKZ with acc = 05: JMP 0000 taken, loop re-fetches at 0000.
        clear_mem();
        put_ins(0, 3'b101, 13'h0100);
        put_ins(2, 3'b001, 13'h0000);
        put_ins(4, 3'b111, 13'h0000);
        mem[13'h0100] = 8'h05;
        run_prog(5, -1);

        // PC wrap: JMP 1FFE, instruction at 1FFE/1FFF, next fetch at 0000.
        clear_mem();
        put_ins(0, 3'b111, 13'h1FFE);
        put_ins(13'h1FFE, 3'b101, 13'h0100);
        mem[13'h0100] = 8'h07;
        run_prog(4, -1);

        // Hold in S3 of ADD: FF + 02 wraps to 01.
        clear_mem();
        put_ins(0, 3'b101, 13'h0100);
        put_ins(2, 3'b010, 13'h0101);
        mem[13'h0100] = 8'hFF;
        mem[13'h0101] = 8'h02;
        run_prog(100, 9);
        check("hold_sum", 32'(alu_accum), 32'(8'h01));

        // Random straight-line programs with forward jumps, random ena.
        for (int t = 0; t < 20; t++) begin
            gen_random();
            run_prog(100, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
